// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: RV32I conditional branch resolution with registered PC select, 2-bit BHT and statistics
module branch_resolve_unit #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 16,
    parameter int IDX_LSB   = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  pred_pc,
    output logic             pred_taken,
    input  logic             res_valid,
    input  logic [XLEN-1:0]  res_pc,
    input  logic             branch,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             lt,
    input  logic             ltu,
    input  logic             res_pred_taken,
    output logic             pc_src,
    output logic             mispredict,
    output logic             illegal_br,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count,
    input  logic             stat_clr
);
    localparam int IW = $clog2(BHT_DEPTH);
    logic [1:0]    bht [BHT_DEPTH];
    logic          fire, legal, taken, upd, miss;
    logic [IW-1:0] ridx;
    logic [1:0]    cur;
    logic          unused;
    assign unused = ^{pred_pc, res_pc};
    always_comb begin
        fire  = res_valid & branch;
        legal = funct3[2:1] != 2'b01;
        // funct3[0] inverts the base condition: BNE/BGE/BGEU are complements of BEQ/BLT/BLTU
        taken = legal & ((funct3[2] ? (funct3[1] ? ltu : lt) : zero) ^ funct3[0]);
        upd   = fire & legal;
        miss  = upd & (taken != res_pred_taken);
        ridx  = res_pc[IDX_LSB +: IW];
        cur   = bht[ridx];
    end
    assign pred_taken = bht[pred_pc[IDX_LSB +: IW]][1];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_src        <= 1'b0;
            mispredict    <= 1'b0;
            illegal_br    <= 1'b0;
            br_count      <= '0;
            mispred_count <= '0;
            for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
        end else begin
            pc_src        <= upd & taken;
            mispredict    <= miss;
            illegal_br    <= fire & !legal;
            br_count      <= stat_clr ? '0 : (upd && !(&br_count)) ? br_count + 1'b1 : br_count;
            mispred_count <= stat_clr ? '0 : (miss && !(&mispred_count)) ? mispred_count + 1'b1 : mispred_count;
            if (upd) bht[ridx] <= taken ? ((&cur) ? cur : cur + 2'b01) : ((|cur) ? cur - 2'b01 : cur);
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: scoreboard bench for branch_resolve_unit (CNT_W=4 build so saturation is reachable)
module tb_branch_resolve_unit;
    localparam int CW = 4;
    localparam int CMAX = 15;
    typedef struct packed {
        logic          ps;
        logic          mp;
        logic          il;
        logic [CW-1:0] bc;
        logic [CW-1:0] mc;
    } exp_t;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   pred_pc = '0;
    logic          pred_taken;
    logic          res_valid = 1'b0;
    logic [31:0]   res_pc = '0;
    logic          branch = 1'b0;
    logic [2:0]    funct3 = '0;
    logic          zero = 1'b0, lt = 1'b0, ltu = 1'b0;
    logic          res_pred_taken = 1'b0;
    logic          pc_src, mispredict, illegal_br;
    logic [CW-1:0] br_count, mispred_count;
    logic          stat_clr = 1'b0;
    int n_vec = 0, n_err = 0;
    int m_bht [16];
    int m_br = 0, m_mis = 0;
    exp_t q[$];
    branch_resolve_unit #(.XLEN(32), .BHT_DEPTH(16), .IDX_LSB(2), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .res_valid(res_valid), .res_pc(res_pc), .branch(branch), .funct3(funct3),
        .zero(zero), .lt(lt), .ltu(ltu), .res_pred_taken(res_pred_taken),
        .pc_src(pc_src), .mispredict(mispredict), .illegal_br(illegal_br),
        .br_count(br_count), .mispred_count(mispred_count), .stat_clr(stat_clr)
    );
    always #5 clk = ~clk;
    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask
    function automatic int midx(input logic [31:0] pc);
        return int'((pc >> 2) & 32'hF);
    endfunction
    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_bht[i] = 1;
        m_br = 0;
        m_mis = 0;
        q.delete();
    endtask
    task automatic check_pred(input string tag, input logic [31:0] pc);
        pred_pc = pc;
        #1;
        chk(tag, {31'b0, pred_taken}, {31'b0, m_bht[midx(pc)] >= 2});
    endtask
    // called 1 time unit after a rising edge; returns 1 time unit after the next one
    task automatic step(input logic v, input logic [31:0] pc, input logic br, input logic [2:0] f3,
                        input logic z, input logic l, input logic lu, input logic pt, input logic clr);
        logic fire, lg, tk;
        exp_t e;
        exp_t o;
        res_valid = v; res_pc = pc; branch = br; funct3 = f3;
        zero = z; lt = l; ltu = lu; res_pred_taken = pt; stat_clr = clr;
        check_pred("pred_pre", pc);
        fire = v & br;
        lg = 1'b1;
        tk = 1'b0;
        case (f3)
            3'b000: tk = z;
            3'b001: tk = !z;
            3'b100: tk = l;
            3'b101: tk = !l;
            3'b110: tk = lu;
            3'b111: tk = !lu;
            default: lg = 1'b0;
        endcase
        e.ps = fire && lg && tk;
        e.mp = fire && lg && (tk != pt);
        e.il = fire && !lg;
        if (clr) begin
            m_br = 0;
            m_mis = 0;
        end else begin
            if (fire && lg && m_br < CMAX) m_br++;
            if (e.mp && m_mis < CMAX) m_mis++;
        end
        if (fire && lg) begin
            if (tk && m_bht[midx(pc)] < 3) m_bht[midx(pc)]++;
            if (!tk && m_bht[midx(pc)] > 0) m_bht[midx(pc)]--;
        end
        e.bc = CW'(m_br);
        e.mc = CW'(m_mis);
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            o = q.pop_front();
            chk("pc_src", {31'b0, pc_src}, {31'b0, o.ps});
            chk("mispredict", {31'b0, mispredict}, {31'b0, o.mp});
            chk("illegal_br", {31'b0, illegal_br}, {31'b0, o.il});
            chk("br_count", {28'b0, br_count}, {28'b0, o.bc});
            chk("mispred_count", {28'b0, mispred_count}, {28'b0, o.mc});
        end
        check_pred("pred_post", pc);
    endtask
    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 3'b000, 1'bx, 1'bx, 1'bx, 1'b0, 1'b0);
    endtask
    initial begin
        logic [2:0] f3s [6];
        logic [2:0] zl [6];
        f3s = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
        zl  = '{3'b100, 3'b000, 3'b010, 3'b000, 3'b001, 3'b000};
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) check_pred("reset_pred", 32'(i) << 2);
        chk("reset_pc_src", {31'b0, pc_src}, 32'd0);
        chk("reset_br_count", {28'b0, br_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle();
        // BEQ taken with a not-taken prediction
        step(1'b1, 32'h40, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_pred("pred_0x40", 32'h40);
        // every legal type taken, predicted taken
        step(1'b0, 32'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++)
            step(1'b1, 32'h100 + 32'(k) * 4, 1'b1, f3s[k], zl[k][2], zl[k][1], zl[k][0], 1'b1, 1'b0);
        // same six types not taken
        for (int k = 0; k < 6; k++)
            step(1'b1, 32'h200 + 32'(k) * 4, 1'b1, f3s[k], !zl[k][2], !zl[k][1], !zl[k][0], 1'b0, 1'b0);
        // BHT saturation on index of 0x8
        for (int k = 0; k < 4; k++) step(1'b1, 32'h8, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b1, 32'h8, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h8, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h8, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // reserved funct3 values, then one idle cycle to prove the pulse ends
        step(1'b1, 32'h8, 1'b1, 3'b010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle();
        step(1'b1, 32'h8, 1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        // fire requires both res_valid and branch
        step(1'b1, 32'h8, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h8, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // drive both counters to saturation
        for (int k = 0; k < 20; k++) step(1'b1, 32'h30, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h30, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h30, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        // randomised traffic
        for (int k = 0; k < 60; k++)
            step(1'($urandom), 32'($urandom_range(0, 255)), 1'($urandom), 3'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0));
        // asynchronous reset while pc_src is high
        step(1'b1, 32'h40, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h40, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        res_valid = 1'b0;
        branch = 1'b0;
        stat_clr = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_pc_src", {31'b0, pc_src}, 32'd0);
        chk("async_br_count", {28'b0, br_count}, 32'd0);
        model_reset();
        check_pred("async_pred", 32'h40);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle();
        step(1'b1, 32'h40, 1'b1, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
